// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter: FSM state encoding and
// the 4-bit slave index to one-hot psel decoder.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int NUM_PSEL = 16;

    function automatic logic [NUM_PSEL-1:0] sel_decode(input logic [3:0] idx);
        sel_decode      = '0;
        sel_decode[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from the requester after the last
// accepted one; the pointer moves only when the grant is actually consumed.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] last_q, last_d;

    // Scan farthest-to-nearest so the nearest requester after last_q overrides.
    always_comb begin
        gnt_o  = '0;
        last_d = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(last_q) + k) % NUM_REQ;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                last_d     = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= IW'(NUM_REQ - 1);
        end else if (adv_i) begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters: round-robin accept,
// IDLE/SETUP/ACCESS sequencing, psel decode and an ACCESS-phase watchdog.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int PADDR_WIDTH  = 32,
    parameter int PWDATA_WIDTH = 32,
    parameter int PRDATA_WIDTH = 32,
    parameter int SEL_LSB      = 12,
    parameter int TIMEOUT      = 256
) (
    input  logic                                  pclock,
    input  logic                                  preset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_write,
    input  logic [NUM_REQ-1:0][PADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][PWDATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                    req_ready,
    output logic [NUM_REQ-1:0]                    rsp_valid,
    output logic [PRDATA_WIDTH-1:0]               rsp_rdata,
    output logic                                  rsp_slverr,
    output logic                                  rsp_timeout,
    output logic [PADDR_WIDTH-1:0]                paddr,
    output logic                                  prwd,
    output logic [PWDATA_WIDTH-1:0]               pwdata,
    output logic [NUM_PSEL-1:0]                   psel,
    output logic                                  penable,
    input  logic [PRDATA_WIDTH-1:0]               prdata,
    input  logic                                  pready,
    input  logic                                  pslverr
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                    state_q;
    logic [NUM_REQ-1:0]        gnt, gnt_q, rsp_valid_q;
    logic [WDW-1:0]            wd_q;
    logic [PADDR_WIDTH-1:0]    paddr_q, sel_addr;
    logic [PWDATA_WIDTH-1:0]   pwdata_q, sel_wdata;
    logic [PRDATA_WIDTH-1:0]   rsp_rdata_q;
    logic [NUM_PSEL-1:0]       psel_q;
    logic                      prwd_q, penable_q, rsp_slverr_q, rsp_timeout_q;
    logic                      sel_write, accept;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk_i (pclock),
        .rst_i (preset),
        .req_i (req_valid),
        .adv_i (accept),
        .gnt_o (gnt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i];
                sel_wdata = req_wdata[i];
                sel_write = req_write[i];
            end
        end
    end

    // gnt is non-zero only when some req_valid is set, so ready implies accept.
    assign accept    = (state_q == IDLE) && (|req_valid);
    assign req_ready = (state_q == IDLE) ? gnt : '0;

    always_ff @(posedge pclock) begin
        if (preset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            wd_q          <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            prwd_q        <= 1'b0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= SETUP;
                        gnt_q    <= gnt;
                        paddr_q  <= sel_addr;
                        pwdata_q <= sel_wdata;
                        prwd_q   <= sel_write;
                        psel_q   <= sel_decode(sel_addr[SEL_LSB +: 4]);
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                    wd_q      <= '0;
                end
                ACCESS: begin
                    // pready wins over a watchdog expiry in the same cycle.
                    if (pready) begin
                        state_q       <= IDLE;
                        psel_q        <= '0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= gnt_q;
                        rsp_rdata_q   <= prwd_q ? '0 : prdata;
                        rsp_slverr_q  <= pslverr;
                        rsp_timeout_q <= 1'b0;
                    end else if ((TIMEOUT > 0) && (wd_q == WD_LAST)) begin
                        state_q       <= IDLE;
                        psel_q        <= '0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= gnt_q;
                        rsp_rdata_q   <= '0;
                        rsp_slverr_q  <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign prwd        = prwd_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vector table, round-robin and reset
// sequences, then randomized traffic against a transaction-level model.
module tb_apb_master_arbiter;

    localparam int NR  = 4;
    localparam int TMO = 4;
    localparam int SL  = 12;

    logic               pclock, preset;
    logic [NR-1:0]      req_valid, req_write, req_ready, rsp_valid;
    logic [NR-1:0][31:0] req_addr, req_wdata;
    logic [31:0]        rsp_rdata, paddr, pwdata, prdata;
    logic               rsp_slverr, rsp_timeout, prwd, penable, pready, pslverr;
    logic [15:0]        psel;

    apb_master_arbiter #(.NUM_REQ(NR), .PADDR_WIDTH(32), .PWDATA_WIDTH(32),
                         .PRDATA_WIDTH(32), .SEL_LSB(SL), .TIMEOUT(TMO)) dut (
        .pclock(pclock), .preset(preset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .prwd(prwd), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    int checks = 0;
    int errors = 0;

    // requester-side model state
    logic [NR-1:0] pend;
    logic [31:0]   t_addr [NR];
    logic [31:0]   t_wdata[NR];
    logic          t_wr   [NR];
    int            m_last;
    bit            hold, rnd;

    // expected / observed response
    logic [NR-1:0] exp_rspv;
    logic [31:0]   exp_rdata, o_rdata;
    logic          exp_err, exp_to, o_err, o_to;
    bit            rsp_pending;
    int            o_gnt;
    logic [15:0]   o_psel;

    typedef struct {
        int          req;
        logic        wr;
        logic [31:0] addr, wdata;
        int          waits;
        logic [31:0] rd;
        logic        err;
        logic [15:0] e_psel;
        logic [31:0] e_rdata;
        logic        e_err, e_to;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclock);
        #1;
    endtask

    task automatic apply();
        req_valid = pend;
        for (int i = 0; i < NR; i++) begin
            req_addr[i]  = t_addr[i];
            req_wdata[i] = t_wdata[i];
            req_write[i] = t_wr[i];
        end
    endtask

    function automatic int pick(input logic [NR-1:0] p, input int last);
        for (int k = 1; k <= NR; k++)
            if (p[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] r;
        r = '0;
        if (i >= 0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic new_req(input int i);
        pend[i]    = 1'b1;
        t_addr[i]  = $urandom;
        t_wdata[i] = $urandom;
        t_wr[i]    = 1'($urandom_range(0, 1));
    endtask

    task automatic arrive();
        for (int i = 0; i < NR; i++)
            if (!pend[i] && $urandom_range(0, 3) == 0) new_req(i);
    endtask

    task automatic check_rsp();
        chk("rsp_valid", rsp_valid, exp_rspv);
        if (rsp_pending) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_slverr", rsp_slverr, exp_err);
            chk("rsp_timeout", rsp_timeout, exp_to);
            chk("rsp_psel_off", psel, 16'h0);
            chk("rsp_penable_off", penable, 1'b0);
            o_rdata = rsp_rdata;
            o_err   = rsp_slverr;
            o_to    = rsp_timeout;
        end
        rsp_pending = 0;
        exp_rspv    = '0;
    endtask

    task automatic chk_zero();
        chk("zero_psel", psel, 16'h0);
        chk("zero_penable", penable, 1'b0);
        chk("zero_paddr", paddr, 32'h0);
        chk("zero_prwd", prwd, 1'b0);
        chk("zero_pwdata", pwdata, 32'h0);
        chk("zero_req_ready", req_ready, '0);
        chk("zero_rsp_valid", rsp_valid, '0);
        chk("zero_rsp_rdata", rsp_rdata, 32'h0);
        chk("zero_rsp_slverr", rsp_slverr, 1'b0);
        chk("zero_rsp_timeout", rsp_timeout, 1'b0);
    endtask

    // One full transfer starting from an IDLE cycle; the response is checked
    // in the following IDLE cycle (next xfer or flush).
    task automatic xfer(input int waits, input logic [31:0] rd, input logic err);
        int w, last_k;
        logic [15:0] ep;
        logic [31:0] a, d;
        logic wr, to;
        apply();
        pready = 1'b0;
        @(negedge pclock);
        w = pick(pend, m_last);
        check_rsp();
        chk("req_ready", req_ready, onehot(w));
        a  = t_addr[w];
        d  = t_wdata[w];
        wr = t_wr[w];
        ep = 16'h1 << a[SL +: 4];
        o_gnt = w;
        tick();
        pend[w] = hold;
        m_last  = w;
        if (rnd) arrive();
        apply();
        @(negedge pclock);
        o_psel = psel;
        chk("setup_psel", psel, ep);
        chk("setup_penable", penable, 1'b0);
        chk("setup_paddr", paddr, a);
        chk("setup_prwd", prwd, wr);
        chk("setup_pwdata", pwdata, d);
        chk("setup_ready", req_ready, '0);
        tick();
        last_k = (waits < TMO) ? waits : TMO - 1;
        for (int k = 0; k <= last_k; k++) begin
            if (rnd) arrive();
            apply();
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : $urandom;
            pslverr = (k == waits) ? err : 1'($urandom_range(0, 1));
            @(negedge pclock);
            chk("acc_penable", penable, 1'b1);
            chk("acc_psel", psel, ep);
            chk("acc_paddr", paddr, a);
            chk("acc_prwd", prwd, wr);
            chk("acc_pwdata", pwdata, d);
            chk("acc_ready", req_ready, '0);
            chk("acc_rspv", rsp_valid, '0);
            tick();
        end
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        to          = (waits >= TMO);
        exp_rspv    = onehot(w);
        exp_rdata   = to ? 32'h0 : (wr ? 32'h0 : rd);
        exp_err     = to ? 1'b1 : err;
        exp_to      = to;
        rsp_pending = 1;
    endtask

    task automatic flush();
        apply();
        @(negedge pclock);
        check_rsp();
        tick();
        @(negedge pclock);
        check_rsp();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int order[8];
        int exp_ord[8];
        exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
        vt[0] = '{0, 1'b1, 32'h0000_3010, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 16'h0008, 32'h0,         1'b0, 1'b0};
        vt[1] = '{2, 1'b0, 32'h0000_F000, 32'h1111_1111, 3, 32'h1234_5678, 1'b0, 16'h8000, 32'h1234_5678, 1'b0, 1'b0};
        vt[2] = '{1, 1'b0, 32'h0000_0ABC, 32'h0,         0, 32'hCAFE_F00D, 1'b1, 16'h0001, 32'hCAFE_F00D, 1'b1, 1'b0};
        vt[3] = '{3, 1'b1, 32'h1234_5678, 32'h5555_AAAA, 1, 32'h7777_7777, 1'b0, 16'h0020, 32'h0,         1'b0, 1'b0};
        vt[4] = '{1, 1'b0, 32'h0000_7004, 32'h0,         9, 32'h9999_9999, 1'b0, 16'h0080, 32'h0,         1'b1, 1'b1};
        vt[5] = '{0, 1'b0, 32'hFFFF_E000, 32'h0,         4, 32'h4444_4444, 1'b0, 16'h4000, 32'h0,         1'b1, 1'b1};
        vt[6] = '{2, 1'b0, 32'h0000_2000, 32'h0,         3, 32'h0BAD_F00D, 1'b0, 16'h0004, 32'h0BAD_F00D, 1'b0, 1'b0};

        preset = 1'b1; pend = '0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        hold = 0; rnd = 0; rsp_pending = 0; exp_rspv = '0; m_last = NR - 1;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = '0; t_wdata[i] = '0; t_wr[i] = 1'b0;
        end
        apply();
        tick(); tick();
        @(negedge pclock);
        chk_zero();
        tick();
        preset = 1'b0;

        // round-robin with all requesters held high from reset
        pend = '1; hold = 1;
        for (int n = 0; n < 8; n++) begin
            xfer(0, $urandom, 1'b0);
            order[n] = o_gnt;
        end
        hold = 0; pend = '0;
        flush();
        for (int n = 0; n < 8; n++) begin
            chk("rr_order", order[n], exp_ord[n]);
            if (n > 0) chk("rr_no_repeat", order[n] == order[n-1], 1'b0);
        end

        // directed vectors
        for (int v = 0; v < 7; v++) begin
            pend = '0;
            pend[vt[v].req]    = 1'b1;
            t_addr[vt[v].req]  = vt[v].addr;
            t_wdata[vt[v].req] = vt[v].wdata;
            t_wr[vt[v].req]    = vt[v].wr;
            xfer(vt[v].waits, vt[v].rd, vt[v].err);
            flush();
            chk("tv_gnt", o_gnt, vt[v].req);
            chk("tv_psel", o_psel, vt[v].e_psel);
            chk("tv_rdata", o_rdata, vt[v].e_rdata);
            chk("tv_slverr", o_err, vt[v].e_err);
            chk("tv_timeout", o_to, vt[v].e_to);
        end

        // reset in the middle of ACCESS
        pend = '0; pend[1] = 1'b1;
        t_addr[1] = 32'h0000_9000; t_wdata[1] = 32'h0; t_wr[1] = 1'b0;
        apply();
        @(negedge pclock);
        chk("rst_accept", req_ready, 4'b0010);
        tick();
        pend = '0; apply();
        @(negedge pclock);
        chk("rst_setup_psel", psel, 16'h0200);
        tick();
        pready = 1'b1; preset = 1'b1;
        @(negedge pclock);
        chk("rst_access_penable", penable, 1'b1);
        tick();
        pready = 1'b0; preset = 1'b0;
        @(negedge pclock);
        chk_zero();
        tick();
        @(negedge pclock);
        chk("post_rst_rspv", rsp_valid, '0);
        tick();
        m_last = NR - 1;
        pend = 4'b1101;
        for (int i = 0; i < NR; i++) if (pend[i]) new_req(i);
        xfer(1, 32'h0F0F_0F0F, 1'b0);
        chk("post_rst_gnt", o_gnt, 0);
        pend = '0;
        flush();

        // randomized traffic
        rnd = 1;
        for (int n = 0; n < 150; n++) begin
            if (pend == '0) new_req($urandom_range(0, NR - 1));
            xfer($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 3) == 0));
        end
        rnd = 0;
        pend = '0;
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
